// File: rtl/counter_b4_checker.sv
// Shadow checker for a 4-bit up/down/load counter: predicts Q/load/rco one cycle ahead and
// counts disagreements. Define CM_RCO_CHECK_EN to include the ripple-carry output in the check.
module counter_b4_checker #(
  parameter int unsigned ERR_LIMIT = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             cm_clk,
  input  logic             cm_reset_n,
  input  logic             cm_enable,
  input  logic [1:0]       cm_mode,
  input  logic [3:0]       cm_D,
  input  logic [3:0]       cm_Q,
  input  logic             cm_load,
  input  logic             cm_rco,
  input  logic             cm_clear,
  output logic             cm_mismatch,
  output logic             cm_err_flag,
  output logic [CNT_W-1:0] cm_err_cnt,
  output logic [3:0]       cm_first_exp,
  output logic [3:0]       cm_first_obs,
  output logic             cm_fault,
  output logic [1:0]       cm_state
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StSync  = 2'b01,
    StCheck = 2'b10,
    StFault = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] LimitCnt = CNT_W'(ERR_LIMIT);

  state_e           state_q, state_d;
  logic [3:0]       model_q, model_d;
  logic [1:0]       pend_mode_q;
  logic [3:0]       pend_data_q;
  logic             mismatch_q, mismatch_d;
  logic             err_flag_q, err_flag_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [3:0]       first_exp_q, first_exp_d;
  logic [3:0]       first_obs_q, first_obs_d;

  logic [3:0] exp_val;
  logic       exp_load;
  logic       rco_diff;
  logic       cmp_en;
  logic       diff;

  // Prediction of what the counter shows now, from its value and stimulus one edge ago.
  always_comb begin
    exp_val  = pend_data_q;
    exp_load = 1'b0;
    case (pend_mode_q)
      2'b00:   exp_val = model_q + 4'd1;
      2'b01:   exp_val = model_q - 4'd1;
      2'b10:   exp_val = model_q - 4'd3;
      default: begin
        exp_val  = pend_data_q;
        exp_load = 1'b1;
      end
    endcase
  end

`ifdef CM_RCO_CHECK_EN
  logic exp_rco;

  always_comb begin
    exp_rco = 1'b0;
    case (pend_mode_q)
      2'b00:   exp_rco = (model_q == 4'd15);
      2'b01:   exp_rco = (model_q == 4'd0);
      2'b10:   exp_rco = (model_q < 4'd3);
      default: exp_rco = 1'b0;
    endcase
  end

  assign rco_diff = (cm_rco != exp_rco);
`else
  logic unused_rco;

  assign unused_rco = cm_rco;
  assign rco_diff   = 1'b0;
`endif

  assign cmp_en = (state_q == StCheck) || (state_q == StFault);
  assign diff   = cmp_en && ((cm_Q != exp_val) || (cm_load != exp_load) || rco_diff);

  always_comb begin
    state_d     = state_q;
    model_d     = model_q;
    mismatch_d  = 1'b0;
    err_flag_d  = err_flag_q;
    err_cnt_d   = err_cnt_q;
    first_exp_d = first_exp_q;
    first_obs_d = first_obs_q;

    if (cm_clear) begin
      // Clear drops any mismatch detected on the same edge.
      state_d     = StIdle;
      model_d     = 4'd0;
      err_flag_d  = 1'b0;
      err_cnt_d   = '0;
      first_exp_d = 4'd0;
      first_obs_d = 4'd0;
    end else begin
      if (diff) begin
        mismatch_d = 1'b1;
        err_flag_d = 1'b1;
        if (err_cnt_q != '1) begin
          err_cnt_d = err_cnt_q + CNT_W'(1);
        end
        if (!err_flag_q) begin
          first_exp_d = exp_val;
          first_obs_d = cm_Q;
        end
      end

      unique case (state_q)
        StIdle: begin
          model_d = 4'd0;
          if (cm_enable) begin
            state_d = StSync;
          end
        end
        StSync: begin
          model_d = cm_Q;
          state_d = cm_enable ? StCheck : StIdle;
        end
        StCheck: begin
          // Resync on a mismatch so a single fault is reported once.
          model_d = diff ? cm_Q : exp_val;
          if (err_cnt_d >= LimitCnt) begin
            state_d = StFault;
          end else if (!cm_enable) begin
            state_d = StIdle;
            model_d = 4'd0;
          end
        end
        StFault: begin
          model_d = diff ? cm_Q : exp_val;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge cm_clk) begin
    if (!cm_reset_n) begin
      state_q     <= StIdle;
      model_q     <= 4'd0;
      pend_mode_q <= 2'b00;
      pend_data_q <= 4'd0;
      mismatch_q  <= 1'b0;
      err_flag_q  <= 1'b0;
      err_cnt_q   <= '0;
      first_exp_q <= 4'd0;
      first_obs_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      model_q     <= model_d;
      pend_mode_q <= cm_mode;
      pend_data_q <= cm_D;
      mismatch_q  <= mismatch_d;
      err_flag_q  <= err_flag_d;
      err_cnt_q   <= err_cnt_d;
      first_exp_q <= first_exp_d;
      first_obs_q <= first_obs_d;
    end
  end

  assign cm_mismatch  = mismatch_q;
  assign cm_err_flag  = err_flag_q;
  assign cm_err_cnt   = err_cnt_q;
  assign cm_first_exp = first_exp_q;
  assign cm_first_obs = first_obs_q;
  assign cm_fault     = (state_q == StFault);
  assign cm_state     = state_q;

endmodule

// File: tb/tb_counter_b4_checker.sv
// Directed bench for counter_b4_checker: the bench plays the counter (with optional corruption)
// and a queue of hand-derived checker outputs is compared after every clock edge.
module tb_counter_b4_checker;

`ifdef CM_RCO_CHECK_EN
  localparam bit RcoChk = 1'b1;
`else
  localparam bit RcoChk = 1'b0;
`endif

  logic       cm_clk;
  logic       cm_reset_n;
  logic       cm_enable;
  logic [1:0] cm_mode;
  logic [3:0] cm_D;
  logic [3:0] cm_Q;
  logic       cm_load;
  logic       cm_rco;
  logic       cm_clear;
  logic       cm_mismatch;
  logic       cm_err_flag;
  logic [7:0] cm_err_cnt;
  logic [3:0] cm_first_exp;
  logic [3:0] cm_first_obs;
  logic       cm_fault;
  logic [1:0] cm_state;

  counter_b4_checker #(
    .ERR_LIMIT (4),
    .CNT_W     (8)
  ) dut (
    .cm_clk       (cm_clk),
    .cm_reset_n   (cm_reset_n),
    .cm_enable    (cm_enable),
    .cm_mode      (cm_mode),
    .cm_D         (cm_D),
    .cm_Q         (cm_Q),
    .cm_load      (cm_load),
    .cm_rco       (cm_rco),
    .cm_clear     (cm_clear),
    .cm_mismatch  (cm_mismatch),
    .cm_err_flag  (cm_err_flag),
    .cm_err_cnt   (cm_err_cnt),
    .cm_first_exp (cm_first_exp),
    .cm_first_obs (cm_first_obs),
    .cm_fault     (cm_fault),
    .cm_state     (cm_state)
  );

  initial cm_clk = 1'b0;
  always #5 cm_clk = ~cm_clk;

  typedef struct {
    string      tag;
    logic       mis;
    logic [7:0] cnt;
    logic [1:0] st;
    logic [3:0] fe;
    logic [3:0] fo;
  } exp_t;

  exp_t       sb[$];
  int         n_pass = 0;
  int         n_chk  = 0;
  logic [3:0] ctr_q  = 4'd0;
  logic [3:0] e_fe   = 4'd0;
  logic [3:0] e_fo   = 4'd0;

  task automatic chk(input string tag, input string fld, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      $display("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
      $error("%s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
    end
  endtask

  // One clock: drive stimulus, queue the checker outputs expected after the edge, then let the
  // emulated counter respond (xor masks corrupt its outputs) and compare.
  task automatic step(input string tag, input logic rst_n, input logic en, input logic [1:0] mode,
                      input logic [3:0] d, input logic clr, input logic [3:0] qerr,
                      input logic lderr, input logic rcoerr, input logic e_mis,
                      input logic [7:0] e_cnt, input logic [1:0] e_st);
    exp_t       e;
    exp_t       got;
    logic [3:0] nq;
    logic       nld;
    logic       nrco;
    cm_reset_n = rst_n;
    cm_enable  = en;
    cm_mode    = mode;
    cm_D       = d;
    cm_clear   = clr;
    e.tag = tag;
    e.mis = e_mis;
    e.cnt = e_cnt;
    e.st  = e_st;
    e.fe  = e_fe;
    e.fo  = e_fo;
    sb.push_back(e);
    nq   = ctr_q;
    nld  = 1'b0;
    nrco = 1'b0;
    if (en) begin
      case (mode)
        2'b00: begin nq = ctr_q + 4'd1; nrco = (ctr_q == 4'd15); end
        2'b01: begin nq = ctr_q - 4'd1; nrco = (ctr_q == 4'd0);  end
        2'b10: begin nq = ctr_q - 4'd3; nrco = (ctr_q < 4'd3);   end
        default: begin nq = d; nld = 1'b1; end
      endcase
    end
    @(posedge cm_clk);
    #1;
    ctr_q   = nq ^ qerr;
    cm_Q    = ctr_q;
    cm_load = nld ^ lderr;
    cm_rco  = nrco ^ rcoerr;
    got = sb.pop_front();
    chk(got.tag, "mismatch",  32'(cm_mismatch),  32'(got.mis));
    chk(got.tag, "err_cnt",   32'(cm_err_cnt),   32'(got.cnt));
    chk(got.tag, "err_flag",  32'(cm_err_flag),  32'(got.cnt != 8'd0));
    chk(got.tag, "state",     32'(cm_state),     32'(got.st));
    chk(got.tag, "fault",     32'(cm_fault),     32'(got.st == 2'b11));
    chk(got.tag, "first_exp", 32'(cm_first_exp), 32'(got.fe));
    chk(got.tag, "first_obs", 32'(cm_first_obs), 32'(got.fo));
  endtask

  initial begin
    cm_reset_n = 1'b0;
    cm_enable  = 1'b0;
    cm_mode    = 2'b00;
    cm_D       = 4'd0;
    cm_Q       = 4'd0;
    cm_load    = 1'b0;
    cm_rco     = 1'b0;
    cm_clear   = 1'b0;

    //   tag           rst en mode D     clr qerr lde rce  mis cnt st
    step("reset",      0,  0, 2'd0, 4'd0, 0, 4'd0, 0, 0,   0,  0, 2'd0);
    step("idle2sync",  1,  1, 2'd3, 4'd13,0, 4'd0, 0, 0,   0,  0, 2'd1);
    step("sync2chk",   1,  1, 2'd0, 4'd0, 0, 4'd0, 0, 0,   0,  0, 2'd2);
    step("up14",       1,  1, 2'd0, 4'd0, 0, 4'd0, 0, 0,   0,  0, 2'd2);
    step("up15",       1,  1, 2'd0, 4'd0, 0, 4'd0, 0, 0,   0,  0, 2'd2);
    step("up0_rco",    1,  1, 2'd0, 4'd0, 0, 4'd0, 0, 0,   0,  0, 2'd2);
    step("up1",        1,  1, 2'd0, 4'd0, 0, 4'd0, 0, 0,   0,  0, 2'd2);
    step("up2_dn3inj", 1,  1, 2'd2, 4'd0, 0, 4'd1, 0, 0,   0,  0, 2'd2);
    e_fe = 4'd15; e_fo = 4'd14;
    step("dn3_mis",    1,  1, 2'd0, 4'd0, 0, 4'd0, 0, 0,   1,  1, 2'd2);
    step("ld9_inj",    1,  1, 2'd3, 4'd9, 0, 4'd0, 1, 0,   0,  1, 2'd2);
    step("ld_mis",     1,  1, 2'd0, 4'd0, 0, 4'd0, 0, 0,   1,  2, 2'd2);
    step("down1",      1,  1, 2'd1, 4'd0, 0, 4'd0, 0, 0,   0,  2, 2'd2);
    step("inj3",       1,  1, 2'd0, 4'd0, 0, 4'd1, 0, 0,   0,  2, 2'd2);
    step("mis3",       1,  1, 2'd0, 4'd0, 0, 4'd0, 0, 0,   1,  3, 2'd2);
    step("inj4",       1,  1, 2'd0, 4'd0, 0, 4'd1, 0, 0,   0,  3, 2'd2);
    step("mis4_fault", 1,  1, 2'd0, 4'd0, 0, 4'd0, 0, 0,   1,  4, 2'd3);
    step("fault_en0",  1,  0, 2'd0, 4'd0, 0, 4'd0, 0, 0,   0,  4, 2'd3);
    step("fault_cnt",  1,  1, 2'd0, 4'd0, 0, 4'd2, 0, 0,   1,  5, 2'd3);
    e_fe = 4'd0; e_fo = 4'd0;
    step("clear_wins", 1,  1, 2'd0, 4'd0, 1, 4'd0, 0, 0,   0,  0, 2'd0);
    step("idle_hold",  1,  0, 2'd0, 4'd0, 0, 4'd0, 0, 0,   0,  0, 2'd0);
    step("resync",     1,  1, 2'd0, 4'd0, 0, 4'd0, 0, 0,   0,  0, 2'd1);
    step("sync_inj",   1,  1, 2'd0, 4'd0, 0, 4'd1, 0, 0,   0,  0, 2'd2);
    e_fe = 4'd15; e_fo = 4'd14;
    step("err1",       1,  1, 2'd0, 4'd0, 0, 4'd1, 0, 0,   1,  1, 2'd2);
    step("err2",       1,  1, 2'd0, 4'd0, 0, 4'd1, 0, 0,   1,  2, 2'd2);
    step("err3",       1,  1, 2'd0, 4'd0, 0, 4'd1, 0, 0,   1,  3, 2'd2);
    e_fe = 4'd0; e_fo = 4'd0;
    step("rst_mid",    0,  1, 2'd0, 4'd0, 0, 4'd0, 0, 0,   0,  0, 2'd0);
    step("post_rst",   1,  1, 2'd0, 4'd0, 0, 4'd0, 0, 0,   0,  0, 2'd1);
    step("rco_sync",   1,  1, 2'd0, 4'd0, 0, 4'd0, 0, 0,   0,  0, 2'd2);
    step("rco_inj",    1,  1, 2'd0, 4'd0, 0, 4'd0, 0, 1,   0,  0, 2'd2);
    e_fe = RcoChk ? 4'd2 : 4'd0; e_fo = RcoChk ? 4'd2 : 4'd0;
    step("rco_bad1",   1,  1, 2'd0, 4'd0, 0, 4'd0, 0, 1,   RcoChk, RcoChk ? 8'd1 : 8'd0, 2'd2);
    step("rco_bad2",   1,  1, 2'd0, 4'd0, 0, 4'd0, 0, 1,   RcoChk, RcoChk ? 8'd2 : 8'd0, 2'd2);
    step("rco_bad3",   1,  1, 2'd0, 4'd0, 0, 4'd0, 0, 0,   RcoChk, RcoChk ? 8'd3 : 8'd0, 2'd2);
    step("chk_en0",    1,  0, 2'd0, 4'd0, 0, 4'd0, 0, 0,   0, RcoChk ? 8'd3 : 8'd0, 2'd0);
    step("sync_again", 1,  1, 2'd0, 4'd0, 0, 4'd0, 0, 0,   0, RcoChk ? 8'd3 : 8'd0, 2'd1);
    step("sync_en0",   1,  0, 2'd0, 4'd0, 0, 4'd0, 0, 0,   0, RcoChk ? 8'd3 : 8'd0, 2'd0);
    e_fe = 4'd0; e_fo = 4'd0;
    step("clear_idle", 1,  0, 2'd0, 4'd0, 1, 4'd0, 0, 0,   0,  0, 2'd0);
    step("ld0",        1,  1, 2'd3, 4'd0, 0, 4'd0, 0, 0,   0,  0, 2'd1);
    step("sat_sync",   1,  1, 2'd0, 4'd0, 0, 4'd1, 0, 0,   0,  0, 2'd2);
    e_fe = 4'd1; e_fo = 4'd0;
    // Counter stuck at 0 while up-counting: every compare mismatches until the count saturates.
    for (int i = 1; i <= 258; i++) begin
      step("sat", 1, 1, 2'd0, 4'd0, 0, 4'd1, 0, 0, 1,
           (i > 255) ? 8'd255 : 8'(i), (i >= 4) ? 2'd3 : 2'd2);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
